// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the parametrised UART receiver.
//               Provides the receive FSM state type, the parity-mode
//               encodings, the oversampling tick positions used for the
//               majority vote, and the 2-of-3 vote helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_rx_state_t;

    localparam int UART_PARITY_NONE = 0;
    localparam int UART_PARITY_ODD  = 1;
    localparam int UART_PARITY_EVEN = 2;

    // Positions within the 16-tick bit cell where the line is sampled.
    localparam logic [3:0] c_SAMPLE_TICK_0 = 4'd7;
    localparam logic [3:0] c_SAMPLE_TICK_1 = 4'd8;
    localparam logic [3:0] c_SAMPLE_TICK_2 = 4'd9;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : Synchronous FIFO with a combinational head output.
//               Push and pop may happen on the same edge; a push while full
//               is accepted only if a pop frees the slot in the same cycle,
//               otherwise the word is dropped and oDROP flags it.
// Ports       : iCLOCK, inRESET (async active-low), iWR_EN/iWR_DATA (push),
//               iRD_EN (pop, ignored when empty), oHEAD (entry at read
//               pointer), oEMPTY, oCOUNT (entries held), oDROP (push lost).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int DATA_W  = 10,
    parameter int DEPTH   = 16,
    parameter int DEPTH_N = 4
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               iWR_EN,
    input  logic [DATA_W-1:0]  iWR_DATA,
    input  logic               iRD_EN,
    output logic [DATA_W-1:0]  oHEAD,
    output logic               oEMPTY,
    output logic [DEPTH_N:0]   oCOUNT,
    output logic               oDROP
);

    localparam logic [DEPTH_N:0] c_FULL_COUNT = DEPTH[DEPTH_N:0];

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DEPTH_N-1:0] r_wr_ptr;
    logic [DEPTH_N-1:0] r_rd_ptr;
    logic [DEPTH_N:0]   r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full = (r_count == c_FULL_COUNT);
    assign oEMPTY = (r_count == '0);
    assign w_pop  = iRD_EN && !oEMPTY;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = iWR_EN && (!w_full || w_pop);
    assign oDROP  = iWR_EN && w_full && !w_pop;

    always_ff @(posedge iCLOCK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= iWR_DATA;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign oHEAD  = r_mem[r_rd_ptr];
    assign oCOUNT = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_receiver_param.sv
// ============================================================================
// Module      : uart_receiver_param
// Description : Parametrised UART receive core, 16x oversampling with a
//               2-of-3 majority vote at ticks 7/8/9 of each bit. Received
//               words are queued in an internal FIFO with per-entry framing
//               (and optionally parity) error flags.
// Option      : UART_RX_PARITY_EN - adds the PARITY state; P_PARITY_MODE
//               then selects none/odd/even. Without it parity is absent and
//               oRD_PARITY_ERR is tied low.
// Ports       : iCLOCK, inRESET (async active-low), iUART_RXD (serial in,
//               idle high), oRD_VALID/iRD_REQ/oRD_DATA/oRD_FRAME_ERR/
//               oRD_PARITY_ERR (FIFO read side), oFIFO_COUNT, oOVERFLOW
//               (sticky) / iOVERFLOW_CLEAR, oBUSY (FSM not idle).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_receiver_param
    import uart_rx_pkg::*;
#(
    parameter int P_CLK_DIV      = 27,
    parameter int P_DATA_BITS    = 8,
    parameter int P_STOP_BITS    = 1,
    parameter int P_PARITY_MODE  = 0,
    parameter int P_FIFO_DEPTH   = 16,
    parameter int P_FIFO_DEPTH_N = 4
) (
    input  logic                     iCLOCK,
    input  logic                     inRESET,
    input  logic                     iUART_RXD,
    output logic                     oRD_VALID,
    input  logic                     iRD_REQ,
    output logic [P_DATA_BITS-1:0]   oRD_DATA,
    output logic                     oRD_FRAME_ERR,
    output logic                     oRD_PARITY_ERR,
    output logic [P_FIFO_DEPTH_N:0]  oFIFO_COUNT,
    output logic                     oOVERFLOW,
    input  logic                     iOVERFLOW_CLEAR,
    output logic                     oBUSY
);

    localparam int               c_DIV_W     = $clog2(P_CLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(P_CLK_DIV - 1);
    localparam logic [3:0]       c_DATA_LAST = 4'(P_DATA_BITS - 1);
    localparam logic [3:0]       c_STOP_LAST = 4'(P_STOP_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam int               c_ENTRY_W   = P_DATA_BITS + 2;
    localparam bit               c_PAR_ON    = (P_PARITY_MODE != UART_PARITY_NONE);
`else
    localparam int               c_ENTRY_W   = P_DATA_BITS + 1;
`endif

    // Elaboration-time guards on the parameter space.
    if (P_PARITY_MODE < 0 || P_PARITY_MODE > 2) begin : g_bad_parity_mode
        $error("uart_receiver_param: P_PARITY_MODE must be 0, 1 or 2");
    end
    if (P_FIFO_DEPTH != (1 << P_FIFO_DEPTH_N)) begin : g_bad_fifo_depth
        $error("uart_receiver_param: P_FIFO_DEPTH must equal 2**P_FIFO_DEPTH_N");
    end

    logic                   r_rxd_meta;
    logic                   r_rxd_sync;
    logic                   r_rxd_prev;
    logic [c_DIV_W-1:0]     r_div_cnt;
    logic [3:0]             r_phase;
    logic                   r_samp_0;
    logic                   r_samp_1;
    uart_rx_state_t         r_state;
    uart_rx_state_t         w_state_next;
    logic [3:0]             r_bit_cnt;
    logic [P_DATA_BITS-1:0] r_shreg;
    logic                   r_frame_err;
    logic                   r_busy;
    logic                   r_overflow;

    logic                   w_tick;
    logic                   w_start_edge;
    logic                   w_vote_en;
    logic                   w_vote;
    logic                   w_push;
    logic                   w_frame_final;
    logic [c_ENTRY_W-1:0]   w_push_data;
    logic [c_ENTRY_W-1:0]   w_head;
    logic                   w_empty;
    logic                   w_drop;

`ifdef UART_RX_PARITY_EN
    logic                   r_parity_err;
    logic                   w_parity_exp;
    assign w_parity_exp = (P_PARITY_MODE == UART_PARITY_ODD) ? ~(^r_shreg) : (^r_shreg);
`endif

    // Synchroniser preset to idle-high so reset release never looks like a start edge.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= iUART_RXD;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    assign w_start_edge = (r_state == IDLE) && r_rxd_prev && !r_rxd_sync;
    assign w_tick       = (r_div_cnt == c_DIV_MAX);

    // Free-running tick divider and bit-phase counter, both realigned on a start edge.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_div_cnt <= '0;
            r_phase   <= '0;
            r_samp_0  <= 1'b1;
            r_samp_1  <= 1'b1;
        end else begin
            if (w_start_edge) begin
                r_div_cnt <= '0;
                r_phase   <= '0;
            end else if (w_tick) begin
                r_div_cnt <= '0;
                r_phase   <= r_phase + 4'd1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            if (w_tick && r_phase == c_SAMPLE_TICK_0) begin
                r_samp_0 <= r_rxd_sync;
            end
            if (w_tick && r_phase == c_SAMPLE_TICK_1) begin
                r_samp_1 <= r_rxd_sync;
            end
        end
    end

    // The third sample is the live value at tick 9, where the vote is taken.
    assign w_vote_en = w_tick && (r_phase == c_SAMPLE_TICK_2);
    assign w_vote    = majority3(r_samp_0, r_samp_1, r_rxd_sync);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_edge) w_state_next = START;
            end
            START: begin
                if (w_vote_en) w_state_next = w_vote ? IDLE : DATA;
            end
            DATA: begin
                if (w_vote_en && r_bit_cnt == c_DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = c_PAR_ON ? PARITY : STOP;
`else
                    w_state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_vote_en) w_state_next = STOP;
            end
`endif
            STOP: begin
                // Leave mid-bit so the next start edge is caught even back-to-back.
                if (w_vote_en && r_bit_cnt == c_STOP_LAST) begin
                    w_state_next = IDLE;
                    w_push       = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        r_bit_cnt    <= '0;
                        r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= 1'b0;
`endif
                    end
                end
                DATA: begin
                    if (w_vote_en) begin
                        r_shreg   <= {w_vote, r_shreg[P_DATA_BITS-1:1]};
                        // Reused as the stop-bit counter once data is complete.
                        r_bit_cnt <= (r_bit_cnt == c_DATA_LAST) ? 4'd0 : r_bit_cnt + 4'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_vote_en) r_parity_err <= (w_vote != w_parity_exp);
                end
`endif
                STOP: begin
                    if (w_vote_en) begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (!w_vote) r_frame_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The final stop vote is folded in directly since it is pushed on the same edge.
    assign w_frame_final = r_frame_err | ~w_vote;
`ifdef UART_RX_PARITY_EN
    assign w_push_data = {r_parity_err, w_frame_final, r_shreg};
`else
    assign w_push_data = {w_frame_final, r_shreg};
`endif

    uart_rx_fifo #(
        .DATA_W  (c_ENTRY_W),
        .DEPTH   (P_FIFO_DEPTH),
        .DEPTH_N (P_FIFO_DEPTH_N)
    ) u_fifo (
        .iCLOCK   (iCLOCK),
        .inRESET  (inRESET),
        .iWR_EN   (w_push),
        .iWR_DATA (w_push_data),
        .iRD_EN   (iRD_REQ),
        .oHEAD    (w_head),
        .oEMPTY   (w_empty),
        .oCOUNT   (oFIFO_COUNT),
        .oDROP    (w_drop)
    );

    // Sticky overflow; a new drop in the same cycle as a clear wins.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (iOVERFLOW_CLEAR) begin
            r_overflow <= 1'b0;
        end
    end

    assign oRD_VALID     = !w_empty;
    assign oRD_DATA      = oRD_VALID ? w_head[P_DATA_BITS-1:0] : '0;
    assign oRD_FRAME_ERR = oRD_VALID & w_head[P_DATA_BITS];
`ifdef UART_RX_PARITY_EN
    assign oRD_PARITY_ERR = oRD_VALID & w_head[P_DATA_BITS+1];
`else
    assign oRD_PARITY_ERR = 1'b0;
`endif
    assign oOVERFLOW     = r_overflow;
    assign oBUSY         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver_param.sv
// ============================================================================
// Module      : tb_uart_receiver_param
// Description : Directed self-checking bench for uart_receiver_param with
//               P_CLK_DIV=4 (64 clocks per bit), 8 data bits, 1 stop bit,
//               16-entry FIFO. Even parity when UART_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_receiver_param;

    localparam int c_CLK_DIV = 4;
    localparam int c_BIT_CYC = 16 * c_CLK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int c_PAR_MODE = 2;
    localparam bit c_PAR_ON   = 1'b1;
`else
    localparam int c_PAR_MODE = 0;
    localparam bit c_PAR_ON   = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       rd_req;
    logic       ovf_clr;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       frame_err;
    logic       parity_err;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_receiver_param #(
        .P_CLK_DIV      (c_CLK_DIV),
        .P_DATA_BITS    (8),
        .P_STOP_BITS    (1),
        .P_PARITY_MODE  (c_PAR_MODE),
        .P_FIFO_DEPTH   (16),
        .P_FIFO_DEPTH_N (4)
    ) dut (
        .iCLOCK          (clk),
        .inRESET         (rst_n),
        .iUART_RXD       (rxd),
        .oRD_VALID       (rd_valid),
        .iRD_REQ         (rd_req),
        .oRD_DATA        (rd_data),
        .oRD_FRAME_ERR   (frame_err),
        .oRD_PARITY_ERR  (parity_err),
        .oFIFO_COUNT     (fifo_count),
        .oOVERFLOW       (overflow),
        .iOVERFLOW_CLEAR (ovf_clr),
        .oBUSY           (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic line_bits(input logic v, input int nbits);
        rxd = v;
        repeat (nbits * c_BIT_CYC) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input logic par_force, input logic par_v, input int gap_cyc);
        line_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) line_bits(d[i], 1);
        if (c_PAR_ON) line_bits(par_force ? par_v : ^d, 1);
        line_bits(stop_v, 1);
        rxd = 1'b1;
        repeat (gap_cyc) @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp_d,
                             input logic exp_ferr, input logic exp_perr);
        check_val({tag, "_valid"}, rd_valid, 1);
        check_val({tag, "_data"}, rd_data, exp_d);
        check_val({tag, "_ferr"}, frame_err, exp_ferr);
        check_val({tag, "_perr"}, parity_err, exp_perr);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        rxd     = 1'b1;
        rd_req  = 1'b0;
        ovf_clr = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rst_valid", rd_valid, 0);
        check_val("rst_count", fifo_count, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_data", rd_data, 0);
        check_val("rst_ferr", frame_err, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_val("idle_busy", busy, 0);

        // Two back-to-back frames at the exact rate.
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'h0A, 1'b1, 1'b0, 1'b0, c_BIT_CYC);
        check_val("b2b_count", fifo_count, 2);
        check_val("b2b_busy", busy, 0);
        pop_check("b2b_0", 8'h55, 1'b0, 1'b0);
        pop_check("b2b_1", 8'h0A, 1'b0, 1'b0);
        check_val("b2b_empty", rd_valid, 0);

        // Short low glitch: false start, nothing pushed.
        rxd = 1'b0;
        repeat (3 * c_CLK_DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        check_val("glitch_busy_hi", busy, 1);
        repeat (16 * c_CLK_DIV) @(negedge clk);
        check_val("glitch_busy_lo", busy, 0);
        check_val("glitch_count", fifo_count, 0);

        // Bad stop bit, then a clean frame.
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0, c_BIT_CYC);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, c_BIT_CYC);
        pop_check("ferr_0", 8'hA3, 1'b1, 1'b0);
        pop_check("ferr_1", 8'h11, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, c_BIT_CYC);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, c_BIT_CYC);
        pop_check("par_bad", 8'h07, 1'b0, 1'b1);
        pop_check("par_ok", 8'h07, 1'b0, 1'b0);
`endif

        // Fill past capacity without popping.
        for (int i = 0; i < 17; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0, 1'b0, 16);
        check_val("ovf_count", fifo_count, 16);
        check_val("ovf_flag", overflow, 1);
        check_val("ovf_head", rd_data, 8'h20);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check_val("ovf_clear", overflow, 0);
        for (int i = 0; i < 16; i++) pop_check($sformatf("fifo_%0d", i), 8'h20 + 8'(i), 1'b0, 1'b0);
        check_val("fifo_drained", fifo_count, 0);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        check_val("empty_pop_count", fifo_count, 0);
        check_val("empty_pop_valid", rd_valid, 0);

        // Reset in the middle of the data bits of 0xFF.
        line_bits(1'b0, 1);
        line_bits(1'b1, 3);
        check_val("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("mid_rst_busy", busy, 0);
        rst_n = 1'b1;
        line_bits(1'b1, 7);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, c_BIT_CYC);
        check_val("post_rst_count", fifo_count, 1);
        pop_check("post_rst", 8'h3C, 1'b0, 1'b0);
        check_val("post_rst_empty", fifo_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_receiver_param.md
Name: uart_receiver_param

Overview:
- Synthesizable, parametrised UART receive core. Successor to the simulation-only fixed 115200/8N1 receiver model.
- Uses 16x oversampling with majority voting. Supports configurable data width and stop bits, plus optional parity.
- Detects framing, parity and overflow errors.
- Buffers received words in an internal FIFO. Sits between the board RXD pin and the SoC UART register block.

Parameters:
- P_CLK_DIV, 27: iCLOCK cycles per 1/16 bit tick (50 MHz / 115200 / 16). Legal values are 2 and up.
- P_DATA_BITS, 8: data bits per frame. Legal range is 5..9.
- P_STOP_BITS, 1: stop bits checked, 1 or 2.
- P_PARITY_MODE, 0: 0 = none, 1 = odd, 2 = even. Honoured only with UART_RX_PARITY_EN.
- P_FIFO_DEPTH, 16: FIFO entries. Must be a power of 2.
- P_FIFO_DEPTH_N, 4: log2(P_FIFO_DEPTH).

Ports:
- iCLOCK  in  1  system clock.
- inRESET  in  1  asynchronous, active-low reset.
- iUART_RXD  in  1  serial input, asynchronous, idle high.
- oRD_VALID  out  1  FIFO not empty.
- iRD_REQ  in  1  pop request.
- oRD_DATA  out  P_DATA_BITS  head-of-FIFO data.
- oRD_FRAME_ERR  out  1  head entry stop-bit error.
- oRD_PARITY_ERR  out  1  head entry parity error (0 without macro).
- oFIFO_COUNT  out  P_FIFO_DEPTH_N+1  entries held.
- oOVERFLOW  out  1  sticky overflow flag.
- iOVERFLOW_CLEAR  in  1  clears oOVERFLOW.
- oBUSY  out  1  receive FSM not in IDLE.

Behaviour:
- Reset (inRESET=0, async):
  - All outputs go to 0; FIFO becomes empty; FSM goes to IDLE.
  - Synchroniser flops preset to 1, so no false start is seen at reset release.
  - Reset mid-frame discards the partial frame.
- Input sync: iUART_RXD passes through 2 flops; all logic uses the synchronised value.
- Tick generator: a counter 0..P_CLK_DIV-1 issues a 1-cycle tick at wrap. It runs freely and is restarted on start-edge detect.
- Bit-phase counter: 4 bits, counts ticks 0..15 within each bit.
- Majority sample: the bit value is the 2-of-3 vote of the samples at ticks 7, 8 and 9, evaluated at tick 9.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a synchronised falling edge goes to START; the phase counter is reset to 0.
  - START: at the vote, value 0 goes to DATA. Value 1 is a false start: return to IDLE, nothing pushed.
  - DATA: shifts LSB first, {bit, shreg[N-1:1]}. After P_DATA_BITS votes, go to PARITY if parity is enabled, else STOP.
  - PARITY: the vote is compared with the parity computed over the data bits. A mismatch sets the entry parity error.
  - STOP: P_STOP_BITS votes. Any 0 sets the entry framing error.
- STOP exit and push:
  - After the last stop vote (tick 9, not tick 15), push {parity_err, frame_err, data} and return to IDLE. This allows resync on back-to-back frames.
  - A framing error with data 0 (break) is pushed as a normal errored entry.
- FIFO:
  - Push and pop take effect on the same clock edge.
  - The head entry is combinationally visible on oRD_DATA / oRD_*_ERR while oRD_VALID=1.
  - Pop occurs when iRD_REQ && oRD_VALID. iRD_REQ while empty is ignored.
  - Simultaneous push and pop when full: accepted, count unchanged, no overflow.
  - Push when full without pop: word dropped, oOVERFLOW set to 1 in the next cycle.
  - Pointers wrap modulo P_FIFO_DEPTH.
- Overflow flag: iOVERFLOW_CLEAR clears oOVERFLOW. If clear and a new overflow occur in the same cycle, set wins.
- oBUSY = (state != IDLE), registered.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the PARITY state exists and P_PARITY_MODE 1/2 select odd/even parity. Mode 0 skips the state.
- Undefined:
  - PARITY state and parity logic are absent, and P_PARITY_MODE is ignored.
  - oRD_PARITY_ERR is tied to 0 and the FIFO entry width drops by 1.

Decomposition:
- Package uart_rx_pkg:
  - state enum typedef uart_rx_state_t.
  - Parity mode constants UART_PARITY_NONE/ODD/EVEN.
  - Sample tick constants (7, 8, 9).
  - Function for the majority vote.
- Sub-module uart_rx_fifo: parametrised sync FIFO on the same iCLOCK/inRESET, with data width and depth parameters and a count output.

Test Plan:
- P_CLK_DIV=4, 8N1: send 0x55, then 0x0A, at the exact rate -> two entries 0x55, 0x0A, no errors, oFIFO_COUNT=2.
- Low glitch of 3 ticks on idle RXD -> false start, FIFO stays empty, oBUSY returns to 0 within 16 ticks.
- Frame 0xA3 with stop bit driven 0 -> entry 0xA3, oRD_FRAME_ERR=1; the next clean frame 0x11 has no error.
- With UART_RX_PARITY_EN, even parity, send 0x07 with parity bit 0 (wrong) -> oRD_PARITY_ERR=1. Resend with parity bit 1 -> 0.
- Send 17 frames with no pops, depth 16 -> oFIFO_COUNT=16, oOVERFLOW=1, head=frame 1. Pulse iOVERFLOW_CLEAR -> 0. Pop 16 entries -> frames 1..16 in order.
- Assert inRESET mid-DATA of 0xFF, then release and send 0x3C -> only 0x3C is received.
